mem_port_arbiter: RTL

Sequencer/arbiter that shares the CPU's single-port synchronous data/instruction RAM between three requesters: load/store (LS), instruction fetch (IF) and the I/O/display reader (IO). It sits between the CPU controller's memory-select path and the RAM. It serialises accesses into a fixed three-phase transaction and returns read data with a one-cycle completion pulse to the owning requester.

---
 rtl/cpu_mem_pkg.sv | 9 +
 rtl/mem_arb_pick.sv | 18 +
 rtl/mem_port_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared types and constants for the CPU memory-port arbiter.
package cpu_mem_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, DATA} state_t;
    localparam logic [1:0] REQ_LS = 2'd0;
    localparam logic [1:0] REQ_IF = 2'd1;
    localparam logic [1:0] REQ_IO = 2'd2;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner select, fixed priority LS > IF > IO with
// starvation flags (IF before IO) overriding the base order.
module mem_arb_pick
    import cpu_mem_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] starve,
    output logic       valid,
    output logic [1:0] id
);
    always_comb begin
        valid = |req;
        id = (starve[0] && req[1]) ? REQ_IF :
             (starve[1] && req[2]) ? REQ_IO :
             req[0] ? REQ_LS :
             req[1] ? REQ_IF : REQ_IO;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous RAM port between LS, IF and IO using an
// IDLE/ISSUE/DATA sequence. Define MEM_ARB_STARVE_EN to enable IF/IO anti-starvation.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ls_req,
    input  logic              if_req,
    input  logic              io_req,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    input  logic              ls_we,
    output logic              ls_gnt,
    output logic              if_gnt,
    output logic              io_gnt,
    output logic              ls_done,
    output logic              if_done,
    output logic              io_done,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    state_t            state, state_nx;
    logic [2:0]        req, gnt, done;
    logic [1:0]        starve, win;
    logic              win_v, arb, rd;
    logic [DATA_W-1:0] rdata_q;

    assign req = {io_req, if_req, ls_req};
    assign arb = state != ISSUE;

    mem_arb_pick u_pick (
        .req   (req),
        .starve(starve),
        .valid (win_v),
        .id    (win)
    );

    always_comb begin
        state_nx = (state == ISSUE) ? DATA : win_v ? ISSUE : IDLE;
    end

    // gnt stays one-hot for the ISSUE cycle and is handed straight to done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= '0;
            done      <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rd        <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state  <= state_nx;
            gnt    <= '0;
            done   <= (state == ISSUE) ? gnt : 3'b000;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (state == DATA && rd)
                rdata_q <= mem_rdata;
            if (arb && win_v) begin
                gnt       <= 3'b001 << win;
                mem_en    <= 1'b1;
                mem_we    <= (win == REQ_LS) && ls_we;
                mem_addr  <= (win == REQ_LS) ? ls_addr : (win == REQ_IF) ? if_addr : io_addr;
                mem_wdata <= ls_wdata;
                rd        <= !((win == REQ_LS) && ls_we);
            end
        end
    end

    // Read data is passed through during DATA so it lines up with Done.
    assign rdata   = (state == DATA && rd) ? mem_rdata : rdata_q;
    assign ls_gnt  = gnt[0];
    assign if_gnt  = gnt[1];
    assign io_gnt  = gnt[2];
    assign ls_done = done[0];
    assign if_done = done[1];
    assign io_done = done[2];

`ifdef MEM_ARB_STARVE_EN
    localparam int CW = $clog2(STARVE_MAX + 1);
    for (genvar i = 0; i < 2; i++) begin : g_wait
        logic [CW-1:0] cnt;
        logic          won;
        assign won       = arb && win_v && (win == 2'(i + 1));
        assign starve[i] = cnt == CW'(STARVE_MAX);
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                cnt <= '0;
            else if (!req[i+1] || won)
                cnt <= '0;
            else if (arb && !starve[i])
                cnt <= cnt + 1'b1;
        end
    end
`else
    assign starve = 2'b00;
`endif
endmodule
